// File: rtl/vga_timing_gen.sv
// vga_timing_gen
// Parametrised VGA raster timing generator. Two free-running counters walk the
// raster (active, front porch, sync, back porch on both axes). A registered
// decode stage (stage 0) issues the fetch request and pixel coordinates; LEAD
// further register stages delay the display-side signals, so pixel data
// fetched on req is ready by the time de is asserted.
//
// Ports:
//   clk_25      in   pixel clock
//   reset_n     in   asynchronous active-low reset
//   en          in   advance enable; low freezes counters, stage 0 and pipe
//   h_sync      out  horizontal sync, active level H_POL
//   v_sync      out  vertical sync, active level V_POL
//   de          out  display enable, LEAD cycles behind req
//   req         out  fetch request for (pixel_x, pixel_y)
//   pixel_x     out  column of requested pixel (holds outside active area)
//   pixel_y     out  row of requested pixel (holds outside active area)
//   line_start  out  pulse at column 0 of every line, aligned with de
//   frame_start out  pulse at (0,0), aligned with de
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit H_POL    = 1'b0,
  parameter bit V_POL    = 1'b0,
  parameter int LEAD     = 2,
  parameter int CW       = 10
) (
  input  logic          clk_25,
  input  logic          reset_n,
  input  logic          en,
  output logic          h_sync,
  output logic          v_sync,
  output logic          de,
  output logic          req,
  output logic [CW-1:0] pixel_x,
  output logic [CW-1:0] pixel_y,
  output logic          line_start,
  output logic          frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Region bounds are one bit wider than the counters so that a bound equal
  // to 2^CW (e.g. zero back porch at full counter range) still compares right.
  localparam logic [CW:0] H_ACT_END  = (CW+1)'(H_ACTIVE);
  localparam logic [CW:0] H_SYNC_BEG = (CW+1)'(H_ACTIVE + H_FP);
  localparam logic [CW:0] H_SYNC_END = (CW+1)'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW:0] V_ACT_END  = (CW+1)'(V_ACTIVE);
  localparam logic [CW:0] V_SYNC_BEG = (CW+1)'(V_ACTIVE + V_FP);
  localparam logic [CW:0] V_SYNC_END = (CW+1)'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);

  logic [CW-1:0] h_cnt;
  logic [CW-1:0] v_cnt;
  logic [CW:0]   h_wide;
  logic [CW:0]   v_wide;
  logic          h_last;
  logic          v_last;
  logic          act_d;
  logic          hs_act_d;
  logic          vs_act_d;

  assign h_wide   = {1'b0, h_cnt};
  assign v_wide   = {1'b0, v_cnt};
  assign h_last   = (h_cnt == H_LAST);
  assign v_last   = (v_cnt == V_LAST);
  assign act_d    = (h_wide < H_ACT_END) && (v_wide < V_ACT_END);
  assign hs_act_d = (h_wide >= H_SYNC_BEG) && (h_wide < H_SYNC_END);
  assign vs_act_d = (v_wide >= V_SYNC_BEG) && (v_wide < V_SYNC_END);

  always_ff @(posedge clk_25 or negedge reset_n) begin
    if (!reset_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (en) begin
      if (h_last) begin
        h_cnt <= '0;
        v_cnt <= v_last ? '0 : v_cnt + 1'b1;
      end else begin
        h_cnt <= h_cnt + 1'b1;
      end
    end
  end

  // Index 0 is stage 0; index LEAD drives the display outputs. Syncs are kept
  // as "asserted" flags internally and mapped to polarity only at the port.
  logic [LEAD:0] de_p;
  logic [LEAD:0] hs_p;
  logic [LEAD:0] vs_p;
  logic [LEAD:0] ls_p;
  logic [LEAD:0] fs_p;

  always_ff @(posedge clk_25 or negedge reset_n) begin
    if (!reset_n) begin
      de_p    <= '0;
      hs_p    <= '0;
      vs_p    <= '0;
      ls_p    <= '0;
      fs_p    <= '0;
      pixel_x <= '0;
      pixel_y <= '0;
    end else if (en) begin
      de_p[0] <= act_d;
      hs_p[0] <= hs_act_d;
      vs_p[0] <= vs_act_d;
      ls_p[0] <= (h_cnt == '0);
      fs_p[0] <= (h_cnt == '0) && (v_cnt == '0);
      if (act_d) begin
        pixel_x <= h_cnt;
        pixel_y <= v_cnt;
      end
      for (int i = 1; i <= LEAD; i++) begin
        de_p[i] <= de_p[i-1];
        hs_p[i] <= hs_p[i-1];
        vs_p[i] <= vs_p[i-1];
        ls_p[i] <= ls_p[i-1];
        fs_p[i] <= fs_p[i-1];
      end
    end
  end

  assign req         = de_p[0];
  assign de          = de_p[LEAD];
  assign line_start  = ls_p[LEAD];
  assign frame_start = fs_p[LEAD];
  assign h_sync      = hs_p[LEAD] ^ ~H_POL;
  assign v_sync      = vs_p[LEAD] ^ ~V_POL;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Testbench for vga_timing_gen: three instances (default 640x480 LEAD=2,
// 800x600 LEAD=0 active-high syncs, and a tiny raster LEAD=3 so whole frames
// fit in the run). A reference model maps the number of enabled edges since
// reset to the expected outputs; expectations are queued per edge and a
// monitor pops and compares them on the falling edge.
module tb_vga_timing_gen;

  logic clk_25  = 1'b0;
  logic reset_n = 1'b0;
  logic en      = 1'b0;

  always #20 clk_25 = ~clk_25;

  logic a_hs, a_vs, a_de, a_req, a_ls, a_fs;
  logic [9:0] a_px, a_py;
  logic b_hs, b_vs, b_de, b_req, b_ls, b_fs;
  logic [10:0] b_px, b_py;
  logic c_hs, c_vs, c_de, c_req, c_ls, c_fs;
  logic [4:0] c_px, c_py;

  vga_timing_gen dut_a (
    .clk_25(clk_25), .reset_n(reset_n), .en(en),
    .h_sync(a_hs), .v_sync(a_vs), .de(a_de), .req(a_req),
    .pixel_x(a_px), .pixel_y(a_py), .line_start(a_ls), .frame_start(a_fs)
  );

  vga_timing_gen #(
    .H_ACTIVE(800), .H_FP(40), .H_SYNC(128), .H_BP(88),
    .V_ACTIVE(600), .V_FP(1), .V_SYNC(4), .V_BP(23),
    .H_POL(1'b1), .V_POL(1'b1), .LEAD(0), .CW(11)
  ) dut_b (
    .clk_25(clk_25), .reset_n(reset_n), .en(en),
    .h_sync(b_hs), .v_sync(b_vs), .de(b_de), .req(b_req),
    .pixel_x(b_px), .pixel_y(b_py), .line_start(b_ls), .frame_start(b_fs)
  );

  vga_timing_gen #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(10), .V_FP(2), .V_SYNC(2), .V_BP(3),
    .H_POL(1'b0), .V_POL(1'b1), .LEAD(3), .CW(5)
  ) dut_c (
    .clk_25(clk_25), .reset_n(reset_n), .en(en),
    .h_sync(c_hs), .v_sync(c_vs), .de(c_de), .req(c_req),
    .pixel_x(c_px), .pixel_y(c_py), .line_start(c_ls), .frame_start(c_fs)
  );

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic        de;
    logic        req;
    logic        ls;
    logic        fs;
    logic [15:0] px;
    logic [15:0] py;
  } exp_t;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got=%h expected=%h", nm, $time, got, exp);
    end
  endtask

  // k = enabled edges since reset. After k edges stage 0 holds the decode of
  // raster position k-1, the display side that of position k-1-lead.
  function automatic exp_t model(input int k, input int ha, input int hf, input int hsw,
                                 input int hb, input int va, input int vf, input int vsw,
                                 input int vb, input bit hp, input bit vp, input int lead);
    exp_t e;
    int ht, vt, ft, p, h, v, q;
    ht = ha + hf + hsw + hb;
    vt = va + vf + vsw + vb;
    ft = ht * vt;
    e = '0;
    e.hs = ~hp;
    e.vs = ~vp;
    if (k >= 1) begin
      p = (k - 1) % ft;
      h = p % ht;
      v = p / ht;
      e.req = (h < ha) && (v < va);
      // coordinates of the most recent visible pixel at or before p
      if (v < va) begin
        e.px = 16'((h < ha) ? h : ha - 1);
        e.py = 16'(v);
      end else begin
        e.px = 16'(ha - 1);
        e.py = 16'(va - 1);
      end
    end
    q = k - 1 - lead;
    if (q >= 0) begin
      p = q % ft;
      h = p % ht;
      v = p / ht;
      e.de = (h < ha) && (v < va);
      e.hs = ((h >= ha + hf) && (h < ha + hf + hsw)) ? hp : ~hp;
      e.vs = ((v >= va + vf) && (v < va + vf + vsw)) ? vp : ~vp;
      e.ls = (h == 0);
      e.fs = (p == 0);
    end
    return e;
  endfunction

  function automatic exp_t exp_a(input int k);
    return model(k, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0, 2);
  endfunction
  function automatic exp_t exp_b(input int k);
    return model(k, 800, 40, 128, 88, 600, 1, 4, 23, 1'b1, 1'b1, 0);
  endfunction
  function automatic exp_t exp_c(input int k);
    return model(k, 16, 2, 3, 3, 10, 2, 2, 3, 1'b0, 1'b1, 3);
  endfunction

  exp_t qa[$];
  exp_t qb[$];
  exp_t qc[$];
  int   cnt = 0;

  // Stimulus-side scoreboard feed: one expectation per edge (or per reset).
  always @(posedge clk_25 or negedge reset_n) begin
    int n;
    if (!reset_n) begin
      n = 0;
      qa.delete();
      qb.delete();
      qc.delete();
    end else begin
      n = en ? cnt + 1 : cnt;
    end
    cnt <= n;
    qa.push_back(exp_a(n));
    qb.push_back(exp_b(n));
    qc.push_back(exp_c(n));
  end

  // Monitor: compare whatever the DUTs present against the queued response.
  always @(negedge clk_25) begin
    exp_t e;
    exp_t g;
    if (qa.size() > 0) begin
      e = qa.pop_front();
      g = {a_hs, a_vs, a_de, a_req, a_ls, a_fs, 16'(a_px), 16'(a_py)};
      check("dut_a_outputs", 64'(g), 64'(e));
    end
    if (qb.size() > 0) begin
      e = qb.pop_front();
      g = {b_hs, b_vs, b_de, b_req, b_ls, b_fs, 16'(b_px), 16'(b_py)};
      check("dut_b_outputs", 64'(g), 64'(e));
    end
    if (qc.size() > 0) begin
      e = qc.pop_front();
      g = {c_hs, c_vs, c_de, c_req, c_ls, c_fs, 16'(c_px), 16'(c_py)};
      check("dut_c_outputs", 64'(g), 64'(e));
    end
  end

  // Called right after reset release (posedge+1): walks the first four edges.
  task automatic first_edges();
    @(posedge clk_25); #2;
    check("a_first_req_xy", {a_req, a_px, a_py}, {1'b1, 10'd0, 10'd0});
    check("a_de_edge1", a_de, 1'b0);
    check("b_de_with_req", {b_de, b_req, b_fs, b_ls}, 4'b1111);
    @(posedge clk_25); #2;
    check("a_de_edge2", {a_de, a_fs}, 2'b00);
    @(posedge clk_25); #2;
    check("a_de_fs_edge3", {a_de, a_fs, a_ls}, 3'b111);
    @(posedge clk_25); #2;
    check("a_fs_single", {a_de, a_fs}, 2'b10);
  endtask

  initial begin
    int t;
    repeat (3) @(posedge clk_25);
    #1;
    check("a_reset_vals", {a_hs, a_vs, a_de, a_req, a_ls, a_fs, a_px, a_py}, {2'b11, 4'b0, 20'd0});
    check("b_reset_vals", {b_hs, b_vs, b_de, b_req, b_ls, b_fs}, 6'b0);
    reset_n = 1'b1;
    en      = 1'b1;
    first_edges();

    // 1200 enabled edges: stage 0 at line 1, column 399; stall 37 cycles.
    repeat (1196) @(posedge clk_25);
    #1 en = 1'b0;
    check("stall_px_before", {a_px, a_py}, {10'd399, 10'd1});
    repeat (37) @(posedge clk_25);
    #1;
    check("stall_px_frozen", {a_px, a_py, a_req, a_de}, {10'd399, 10'd1, 1'b1, 1'b1});
    en = 1'b1;
    @(posedge clk_25); #2;
    check("stall_px_resume", a_px, 10'd400);

    repeat (20000) begin
      @(posedge clk_25);
      #1 en = ($urandom_range(0, 9) != 0);
    end

    // Asynchronous reset while the small raster is in vertical sync.
    en = 1'b1;
    t = 0;
    while (c_vs !== 1'b1 && t < 2000) begin
      @(posedge clk_25);
      #1 t++;
    end
    checks++;
    if (t >= 2000) begin
      failures++;
      $display("FAIL c_vsync_wait: v_sync not seen within %0d cycles", t);
    end
    #2 reset_n = 1'b0;
    #1;
    check("a_async_reset", {a_hs, a_vs, a_de, a_req, a_ls, a_fs, a_px, a_py}, {2'b11, 4'b0, 20'd0});
    check("b_async_reset", {b_hs, b_vs, b_de, b_req, b_ls, b_fs, b_px, b_py}, {2'b00, 4'b0, 22'd0});
    check("c_async_reset", {c_hs, c_vs, c_de, c_req, c_ls, c_fs, c_px, c_py}, {2'b10, 4'b0, 10'd0});
    repeat (2) @(posedge clk_25);
    #1 reset_n = 1'b1;
    first_edges();

    repeat (5000) begin
      @(posedge clk_25);
      #1 en = ($urandom_range(0, 3) != 0);
    end
    @(negedge clk_25);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
